// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pkg
//  Description : Shared constants for the write-back stage: write-back source
//                selectors, load funct3 encodings and the default datapath
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Write-back source selector (value 3 is reserved and behaves as ALU)
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Extracts the addressed byte/halfword from a raw memory word
//                and sign- or zero-extends it to the datapath width.
//                Misaligned halfwords are not trapped: the low offset bit is
//                simply ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the load type
    always_comb begin
        byte_sel = rdata[7:0];
        case (lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        half_sel = lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  aligned = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  aligned = {{(XLEN-16){1'b0}}, half_sel};
            default: aligned = rdata;   // LW and unknown encodings: full word
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register and write-back logic. Drives the
//                register-file write port (rd/indata/RegWrite), never writes
//                x0, counts retired instructions and bypasses the value being
//                written this cycle to the ID-stage operand reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [4:0]       in_rd,
    input  logic             in_RegWrite,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [XLEN-1:0]  in_pc4,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [XLEN-1:0]  id_rs1_regval,
    input  logic [XLEN-1:0]  id_rs2_regval,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  indata,
    output logic             RegWrite,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret,
    output logic [XLEN-1:0]  id_rs1_value,
    output logic [XLEN-1:0]  id_rs2_value
);

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            live;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata   (in_mem_rdata),
        .lo      (in_alu_result[1:0]),
        .funct3  (in_funct3),
        .aligned (load_data)
    );

    assign live = in_valid & ~flush;

    // Write-back source select; the reserved encoding falls back to ALU
    always_comb begin
        case (in_wb_sel)
            WB_SEL_LOAD: wb_data = load_data;
            WB_SEL_PC4:  wb_data = in_pc4;
            default:     wb_data = in_alu_result;
        endcase
    end

    // MEM/WB pipeline register and retire counter
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wb_valid <= 1'b0;
            RegWrite <= 1'b0;
            rd       <= 5'd0;
            indata   <= '0;
            instret  <= '0;
        end else begin
            // Counts the instruction leaving WB, so it lags wb_valid by one edge
            if (wb_valid) begin
                instret <= instret + CNT_W'(1);
            end
            wb_valid <= live;
            RegWrite <= live & in_RegWrite & (in_rd != 5'd0);
            rd       <= in_rd;
            indata   <= wb_data;
        end
    end

    // ID-stage bypass: the register file would return the pre-write value
    always_comb begin
        if (id_rs1 == 5'd0)
            id_rs1_value = '0;
        else if (RegWrite && (id_rs1 == rd))
            id_rs1_value = indata;
        else
            id_rs1_value = id_rs1_regval;

        if (id_rs2 == 5'd0)
            id_rs2_value = '0;
        else if (RegWrite && (id_rs2 == rd))
            id_rs2_value = indata;
        else
            id_rs2_value = id_rs2_regval;
    end

endmodule : wb_stage
`default_nettype wire
